// File: rtl/mgmt_master_pkg.sv
// Shared definitions for the management-bus initiator: widths, FSM encoding,
// direction constants and the responder address map.
package mgmt_master_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int WEN_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } mgmt_state_e;

  localparam logic MGMT_RD = 1'b1;
  localparam logic MGMT_WR = 1'b0;

  // Responder decode entries: a responder hits when (adr & MASK) == ADDR
  localparam logic [ADR_W-1:0] ADDR_IRQ = 32'h0000_0100;
  localparam logic [ADR_W-1:0] MASK_IRQ = 32'hFFFF_FFF0;
  localparam logic [ADR_W-1:0] ADDR_TMR = 32'h0000_0200;
  localparam logic [ADR_W-1:0] MASK_TMR = 32'hFFFF_FFF0;

  function automatic logic [DAT_W-1:0] rd_capture(input logic rwn,
                                                  input logic rxe,
                                                  input logic [DAT_W-1:0] rxd);
    return (rwn && rxe) ? rxd : '0;
  endfunction

endpackage

// File: rtl/mgmt_master_if.sv
// Host command/response port and management-bus signals of the initiator.
interface mgmt_master_if;
  import mgmt_master_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [ADR_W-1:0] cmd_adr;
  logic             cmd_rwn;
  logic [WEN_W-1:0] cmd_wen;
  logic [DAT_W-1:0] cmd_wdata;
  logic             rsp_valid;
  logic [DAT_W-1:0] rsp_rdata;
  logic             rsp_err;
  logic             mgmt_req;
  logic [ADR_W-1:0] mgmt_adr;
  logic             mgmt_rwn;
  logic [WEN_W-1:0] mgmt_wen;
  logic [DAT_W-1:0] mgmt_txd;
  logic             mgmt_ack;
  logic             mgmt_rxe;
  logic [DAT_W-1:0] mgmt_rxd;

  modport master (
    input  cmd_valid, cmd_adr, cmd_rwn, cmd_wen, cmd_wdata,
    input  mgmt_ack, mgmt_rxe, mgmt_rxd,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd
  );

  modport slave (
    output cmd_valid, cmd_adr, cmd_rwn, cmd_wen, cmd_wdata,
    output mgmt_ack, mgmt_rxe, mgmt_rxd,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd
  );

endinterface

// File: rtl/mgmt_timeout_ctr.sv
// Clearable up-counter with a terminal-count flag at TERM; used for both the
// request timeout and the post-transaction idle gap.
module mgmt_timeout_ctr #(
  parameter int CW   = 5,
  parameter int TERM = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CW-1:0] TERM_C = CW'(TERM);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TERM_C);

endmodule

// File: rtl/mgmt_master.sv
// Management-bus initiator: takes one host command at a time, holds the bus
// request until acknowledged or timed out, returns one response per command.
module mgmt_master
  import mgmt_master_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int GAP     = 2,
  parameter int CW      = 5
) (
  input  logic          clk,
  input  logic          rst,
  mgmt_master_if.master bus
);

  mgmt_state_e      state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             req_q, req_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             rwn_q, rwn_d;
  logic [WEN_W-1:0] wen_q, wen_d;
  logic [DAT_W-1:0] txd_q, txd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [DAT_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic accept;
  logic req_done;
  logic in_req;
  logic in_gap;
  logic to_tc;
  logic gap_tc;

  assign accept   = (state_q == ST_IDLE) && bus.cmd_valid && cmd_ready_q;
  assign in_req   = (state_q == ST_REQ);
  assign in_gap   = (state_q == ST_GAP);
  assign req_done = in_req && (bus.mgmt_ack || to_tc);

  mgmt_timeout_ctr #(.CW(CW), .TERM(TIMEOUT - 1)) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (in_req),
    .tc_o  (to_tc)
  );

  mgmt_timeout_ctr #(.CW(CW), .TERM(GAP - 1)) u_gap_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (req_done),
    .en_i  (in_gap),
    .tc_o  (gap_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_REQ;
      ST_REQ:  if (req_done) state_d = ST_GAP;
      ST_GAP:  if (gap_tc)   state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Ack takes priority over the timeout terminal count in the same cycle
  always_comb begin
    req_d       = req_q;
    adr_d       = adr_q;
    rwn_d       = rwn_q;
    wen_d       = wen_q;
    txd_d       = txd_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    cmd_ready_d = (state_d == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          adr_d = bus.cmd_adr;
          rwn_d = bus.cmd_rwn;
          wen_d = bus.cmd_wen;
          txd_d = bus.cmd_wdata;
          req_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus.mgmt_ack) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_capture(rwn_q, bus.mgmt_rxe, bus.mgmt_rxd);
        end else if (to_tc) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      default: req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_q <= 1'b0;
      req_q       <= 1'b0;
      adr_q       <= '0;
      rwn_q       <= 1'b0;
      wen_q       <= '0;
      txd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      req_q       <= req_d;
      adr_q       <= adr_d;
      rwn_q       <= rwn_d;
      wen_q       <= wen_d;
      txd_q       <= txd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.mgmt_req  = req_q;
  assign bus.mgmt_adr  = adr_q;
  assign bus.mgmt_rwn  = rwn_q;
  assign bus.mgmt_wen  = wen_q;
  assign bus.mgmt_txd  = txd_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mgmt_master.sv
// Scoreboard bench for mgmt_master: host driver, behavioural responder and a
// negedge monitor that checks bus commands and responses in order.
module tb_mgmt_master;
  import mgmt_master_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int GAP     = 2;

  typedef struct packed {
    logic [31:0] adr;
    logic        rwn;
    logic [1:0]  wen;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;

  mgmt_master_if bus_if ();

  mgmt_master #(.TIMEOUT(TIMEOUT), .GAP(GAP), .CW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  int   checks = 0;
  int   errors = 0;

  // Responder knobs
  bit          resp_en    = 1'b0;
  int          resp_delay = 2;
  logic        resp_rxe   = 1'b0;
  logic [31:0] resp_rxd   = '0;
  bit          noise      = 1'b0;
  bit          stray_gap  = 1'b0;
  int          stray_cnt  = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: acks resp_delay cycles after first seeing req
  initial begin : responder
    int age;
    bit pend;
    int stray_done;
    age = 0;
    pend = 1'b0;
    stray_done = 0;
    bus_if.mgmt_ack = 1'b0;
    bus_if.mgmt_rxe = 1'b0;
    bus_if.mgmt_rxd = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.mgmt_ack = 1'b0;
      bus_if.mgmt_rxe = 1'b0;
      bus_if.mgmt_rxd = '0;
      if (bus_if.mgmt_req) begin
        age++;
        if (resp_en && age == resp_delay + 1) begin
          bus_if.mgmt_ack = 1'b1;
          bus_if.mgmt_rxe = resp_rxe;
          bus_if.mgmt_rxd = resp_rxd;
          pend = stray_gap;
        end else if (noise) begin
          bus_if.mgmt_rxe = 1'b1;
          bus_if.mgmt_rxd = 32'hBAD0_BAD0;
        end
      end else begin
        age = 0;
        if (pend || stray_done != stray_cnt) begin
          bus_if.mgmt_ack = 1'b1;
          bus_if.mgmt_rxe = 1'b1;
          bus_if.mgmt_rxd = 32'h1234_5678;
          if (pend) pend = 1'b0;
          else stray_done++;
        end
      end
    end
  end

  // Monitor: bus command on req rise, stability while high, idle gap, responses
  initial begin : monitor
    bit   prev_req;
    bit   seen;
    bit   stable;
    int   low_run;
    bus_t now_b, cap, exp_b;
    rsp_t got, e;
    prev_req = 1'b0;
    seen = 1'b0;
    stable = 1'b1;
    low_run = 0;
    cap = '0;
    forever begin
      @(negedge clk);
      now_b = {bus_if.mgmt_adr, bus_if.mgmt_rwn, bus_if.mgmt_wen, bus_if.mgmt_txd};
      if (bus_if.mgmt_req) begin
        if (!prev_req) begin
          if (seen) chk("req_low_gap", 96'(low_run >= GAP), 96'(1));
          seen = 1'b1;
          if (exp_bus.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_cmd: unexpected request adr=%0h", now_b.adr);
          end else begin
            exp_b = exp_bus.pop_front();
            chk("bus_cmd", 96'(now_b), 96'(exp_b));
          end
          cap = now_b;
          stable = 1'b1;
        end else if (now_b != cap) begin
          stable = 1'b0;
        end
      end else begin
        if (prev_req) chk("bus_stable", 96'(stable), 96'(1));
        low_run = prev_req ? 1 : low_run + 1;
      end
      prev_req = bus_if.mgmt_req;
      if (bus_if.rsp_valid) begin
        got = {bus_if.rsp_rdata, bus_if.rsp_err};
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp: unexpected response rdata=%0h err=%0b", got.rdata, got.err);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp", 96'(got), 96'(e));
        end
      end
    end
  end

  task automatic send(input logic [31:0] adr, input logic rwn, input logic [1:0] wen,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
    bit rdy;
    int g;
    exp_bus.push_back('{adr, rwn, wen, wd});
    exp_rsp.push_back('{erd, eerr});
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_adr   = adr;
    bus_if.cmd_rwn   = rwn;
    bus_if.cmd_wen   = wen;
    bus_if.cmd_wdata = wd;
    g = 0;
    do begin
      @(negedge clk);
      rdy = bus_if.cmd_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!rdy && g < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_accept: cmd_ready low for %0d cycles, required 1", g);
    end
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!bus_if.cmd_ready && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!bus_if.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: cmd_ready=0 after %0d cycles, required 1", g);
    end
  endtask

  // Called in the first req cycle of a transaction acked 2 cycles after req
  task automatic lat_check();
    int n;
    int m;
    chk("req_first_cycle", 96'(bus_if.mgmt_req), 96'(1));
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus_if.rsp_valid && n < 100);
    chk("rsp_latency", 96'(n), 96'(3));
    chk("req_low_at_rsp", 96'(bus_if.mgmt_req), 96'(0));
    m = 0;
    while (!bus_if.cmd_ready && m < 100) begin
      @(posedge clk);
      #1;
      m++;
    end
    chk("ready_after_gap", 96'(m), 96'(GAP));
  endtask

  task automatic req_high(output int cnt);
    cnt = 0;
    while (bus_if.mgmt_req && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    rst = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_adr   = '0;
    bus_if.cmd_rwn   = 1'b0;
    bus_if.cmd_wen   = '0;
    bus_if.cmd_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 96'(bus_if.mgmt_req), 96'(0));
    chk("rst_cmd_ready", 96'(bus_if.cmd_ready), 96'(0));
    chk("rst_rsp", 96'({bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata}), 96'(0));
    chk("rst_bus", 96'({bus_if.mgmt_adr, bus_if.mgmt_rwn, bus_if.mgmt_wen, bus_if.mgmt_txd}), 96'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_cmd_ready", 96'(bus_if.cmd_ready), 96'(1));

    // Write, acked two cycles after req
    resp_en = 1'b1; resp_delay = 2; resp_rxe = 1'b0; resp_rxd = '0;
    send(ADDR_IRQ | 32'd3, MGMT_WR, 2'b01, 32'd5, 32'd0, 1'b0);
    bus_if.cmd_valid = 1'b0;
    lat_check();

    // Read with read data
    resp_rxe = 1'b1; resp_rxd = 32'h0000_0005;
    send(ADDR_IRQ | 32'd3, MGMT_RD, 2'b00, 32'd0, 32'd5, 1'b0);
    bus_if.cmd_valid = 1'b0;
    lat_check();

    // Read acked without rxe while rxe toggles in non-ack cycles
    noise = 1'b1; resp_rxe = 1'b0; resp_rxd = 32'h0000_0099;
    send(ADDR_TMR | 32'd4, MGMT_RD, 2'b00, 32'h0, 32'd0, 1'b0);
    bus_if.cmd_valid = 1'b0;
    lat_check();
    noise = 1'b0;

    // Timeout on an unmapped address
    resp_en = 1'b0;
    send(32'hDEAD_0000, MGMT_RD, 2'b00, 32'h0, 32'd0, 1'b1);
    bus_if.cmd_valid = 1'b0;
    req_high(cnt);
    chk("timeout_req_cycles", 96'(cnt), 96'(TIMEOUT));
    wait_ready();

    // Ack on the timeout terminal cycle
    resp_en = 1'b1; resp_delay = TIMEOUT - 1; resp_rxe = 1'b1; resp_rxd = 32'hDEAD_BEEF;
    send(ADDR_IRQ, MGMT_RD, 2'b00, 32'h0, 32'hDEAD_BEEF, 1'b0);
    bus_if.cmd_valid = 1'b0;
    req_high(cnt);
    chk("terminal_req_cycles", 96'(cnt), 96'(TIMEOUT));
    wait_ready();

    // Back-to-back with cmd_valid held, stray ack in each GAP
    resp_delay = 2; resp_rxe = 1'b1; resp_rxd = 32'h0000_00A5; stray_gap = 1'b1;
    send(ADDR_IRQ | 32'd1, MGMT_WR, 2'b11, 32'h1111_0001, 32'd0, 1'b0);
    send(ADDR_IRQ | 32'd2, MGMT_RD, 2'b00, 32'h0, 32'h0000_00A5, 1'b0);
    send(ADDR_TMR | 32'd3, MGMT_WR, 2'b10, 32'h3333_0003, 32'd0, 1'b0);
    send(ADDR_TMR | 32'd4, MGMT_RD, 2'b00, 32'h0, 32'h0000_00A5, 1'b0);
    bus_if.cmd_valid = 1'b0;
    wait_ready();
    stray_gap = 1'b0;

    // Stray ack while idle
    stray_cnt++;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_stray", 96'(bus_if.cmd_ready), 96'(1));

    // Async reset in the middle of a request
    resp_en = 1'b0;
    send(ADDR_IRQ | 32'd7, MGMT_RD, 2'b00, 32'h0, 32'd0, 1'b0);
    bus_if.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("reset_req_drop", 96'(bus_if.mgmt_req), 96'(0));
    chk("rsp_pending_at_reset", 96'(exp_rsp.size()), 96'(1));
    exp_rsp.delete();
    @(posedge clk);
    #1;
    chk("reset_no_rsp", 96'(bus_if.rsp_valid), 96'(0));
    chk("reset_cmd_ready", 96'(bus_if.cmd_ready), 96'(0));
    rst = 1'b0;
    resp_en = 1'b1; resp_delay = 2; resp_rxe = 1'b1; resp_rxd = 32'h0000_0077;
    send(ADDR_IRQ | 32'd7, MGMT_RD, 2'b00, 32'h0, 32'h0000_0077, 1'b0);
    bus_if.cmd_valid = 1'b0;
    lat_check();

    repeat (5) @(posedge clk);
    #1;
    chk("rsp_queue_drained", 96'(exp_rsp.size()), 96'(0));
    chk("bus_queue_drained", 96'(exp_bus.size()), 96'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
